// File: rtl/packing_controller_pkg.sv
// Shared definitions for the egg packing controller.
//   state_t         : controller FSM state encoding
//   DOZEN           : eggs per full box
//   BOX_MAX_DEFAULT : default highest box count before box_cnt wraps to 0
package packing_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BOX,
        FILL,
        EJECT,
        FAULT
    } state_t;

    localparam int unsigned DOZEN           = 12;
    localparam int unsigned BOX_MAX_DEFAULT = 99;

endpackage

// File: rtl/packing_controller_dozen_counter.sv
// Egg counter for one box.
//   clk   : system clock
//   rst_n : asynchronous active-low clear
//   en    : count one egg
//   clr   : synchronous clear (has priority over en)
//   count : eggs counted, 0..DOZEN
//   term  : high while count == DOZEN
module dozen_counter
    import packing_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] count,
    output logic       term
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            // Modulo-12 over the values 1..12: an egg counted at a full
            // dozen starts the next dozen.
            if (count == 4'(DOZEN))
                count <= 4'd1;
            else
                count <= count + 4'd1;
        end
    end

    assign term = (count == 4'(DOZEN));

endmodule

// File: rtl/packing_controller.sv
// Egg packing line controller: runs the conveyor while a box is filled,
// ejects each full dozen, counts packed boxes and flags a box lost mid-fill.
//   Ck         : system clock
//   clear      : asynchronous active-low reset
//   start/stop : operator requests (levels)
//   egg_det    : egg sensor, each 0->1 edge is one egg
//   box_in     : box present in the filling position
//   eject_done : ejector finished pushing the box out
//   belt_on    : conveyor enable (FILL)
//   eject      : ejector command (EJECT)
//   dozen      : one-cycle pulse on the 12th egg of a box
//   fault      : box lost during filling (FAULT)
//   egg_cnt    : eggs in current box, 0..12
//   box_cnt    : full boxes packed, 0..BOX_MAX
module packing_controller
    import packing_controller_pkg::*;
#(
    parameter int unsigned BOX_MAX = BOX_MAX_DEFAULT
) (
    input  logic       Ck,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    input  logic       egg_det,
    input  logic       box_in,
    input  logic       eject_done,
    output logic       belt_on,
    output logic       eject,
    output logic       dozen,
    output logic       fault,
    output logic [3:0] egg_cnt,
    output logic [6:0] box_cnt
);

    state_t state;
    state_t state_nxt;
    logic   egg_prev;
    logic   egg_edge;
    logic   last_egg;
    logic   stop_pend;
    logic   cnt_en;
    logic   cnt_clr;
    logic   cnt_full;

    assign egg_edge = egg_det & ~egg_prev;
    assign last_egg = (state == FILL) && egg_edge && (egg_cnt == 4'(DOZEN - 1));

    // An egg that coincides with losing the box is not counted, so the
    // count freezes at its value on entry to FAULT.
    assign cnt_en  = (state == FILL) && egg_edge && !cnt_full && (box_in || last_egg);
    assign cnt_clr = ((state == WAIT_BOX) && !stop && box_in)
                   || ((state == EJECT) && eject_done)
                   || ((state == FAULT) && start && !stop);

    dozen_counter u_dozen_counter (
        .clk   (Ck),
        .rst_n (clear),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .count (egg_cnt),
        .term  (cnt_full)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start && !stop) state_nxt = WAIT_BOX;
            WAIT_BOX: if (stop) state_nxt = IDLE;
                      else if (box_in) state_nxt = FILL;
            FILL:     if (last_egg) state_nxt = EJECT;
                      else if (!box_in) state_nxt = FAULT;
            EJECT:    if (eject_done) state_nxt = (stop_pend || stop) ? IDLE : WAIT_BOX;
            FAULT:    if (start && !stop) state_nxt = WAIT_BOX;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // change on the same edge as the state itself.
    always_ff @(posedge Ck or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            egg_prev  <= 1'b0;
            stop_pend <= 1'b0;
            box_cnt   <= '0;
            belt_on   <= 1'b0;
            eject     <= 1'b0;
            fault     <= 1'b0;
            dozen     <= 1'b0;
        end else begin
            state    <= state_nxt;
            egg_prev <= egg_det;
            belt_on  <= (state_nxt == FILL);
            eject    <= (state_nxt == EJECT);
            fault    <= (state_nxt == FAULT);
            dozen    <= last_egg;

            if (((state == FILL) || (state == EJECT)) && stop)
                stop_pend <= 1'b1;

            if ((state == EJECT) && eject_done) begin
                box_cnt   <= (box_cnt == 7'(BOX_MAX)) ? '0 : box_cnt + 7'd1;
                stop_pend <= 1'b0;
            end

            if ((state == FAULT) && start && !stop)
                stop_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_packing_controller.sv
// Directed self-checking bench for packing_controller. Two instances share
// all inputs: the default-parameter one and one with BOX_MAX=2.
module tb_packing_controller;

    logic       Ck = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       egg_det = 1'b0;
    logic       box_in = 1'b0;
    logic       eject_done = 1'b0;
    logic       belt_on, eject, dozen, fault;
    logic [3:0] egg_cnt;
    logic [6:0] box_cnt;
    logic       belt_on2, eject2, dozen2, fault2;
    logic [3:0] egg_cnt2;
    logic [6:0] box_cnt2;

    int checks = 0;
    int fails  = 0;

    packing_controller dut (
        .Ck(Ck), .clear(clear), .start(start), .stop(stop), .egg_det(egg_det),
        .box_in(box_in), .eject_done(eject_done), .belt_on(belt_on), .eject(eject),
        .dozen(dozen), .fault(fault), .egg_cnt(egg_cnt), .box_cnt(box_cnt)
    );

    packing_controller #(.BOX_MAX(2)) dut2 (
        .Ck(Ck), .clear(clear), .start(start), .stop(stop), .egg_det(egg_det),
        .box_in(box_in), .eject_done(eject_done), .belt_on(belt_on2), .eject(eject2),
        .dozen(dozen2), .fault(fault2), .egg_cnt(egg_cnt2), .box_cnt(box_cnt2)
    );

    always #5 Ck = ~Ck;

    task automatic tick();
        @(posedge Ck);
        #1;
    endtask

    task automatic do_reset();
        start = 0; stop = 0; egg_det = 0; box_in = 0; eject_done = 0;
        clear = 0;
        tick();
        clear = 1;
        tick();
    endtask

    task automatic go_fill();
        start = 1;
        tick();
        start = 0;
        box_in = 1;
        tick();
    endtask

    task automatic egg();
        egg_det = 1;
        tick();
        egg_det = 0;
        tick();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({belt_on, eject, dozen, fault} !== 4'b0000) begin
            fails++; $display("FAIL reset_outputs: got %b expected 0000", {belt_on, eject, dozen, fault});
        end
        checks++;
        if (egg_cnt !== 4'd0 || box_cnt !== 7'd0) begin
            fails++; $display("FAIL reset_counts: got egg=%0d box=%0d expected 0/0", egg_cnt, box_cnt);
        end
        clear = 1;
        tick();
        go_fill();
        for (int i = 0; i < 7; i++) egg();
        checks++;
        if (egg_cnt !== 4'd7 || belt_on !== 1'b1) begin
            fails++; $display("FAIL pre_reset_fill: got egg=%0d belt=%b expected 7/1", egg_cnt, belt_on);
        end
        #2;
        clear = 0;
        #1;
        checks++;
        if (egg_cnt !== 4'd0 || box_cnt !== 7'd0 || belt_on !== 1'b0) begin
            fails++; $display("FAIL async_reset: got egg=%0d box=%0d belt=%b expected 0/0/0", egg_cnt, box_cnt, belt_on);
        end
        #2;
        clear = 1;
        tick();
        tick();
        checks++;
        if (belt_on !== 1'b0) begin
            fails++; $display("FAIL reset_idle: got belt=%b expected 0", belt_on);
        end
    endtask

    task automatic test_normal_fill();
        int pulses;
        do_reset();
        go_fill();
        checks++;
        if (belt_on !== 1'b1) begin
            fails++; $display("FAIL fill_entry: got belt=%b expected 1", belt_on);
        end
        pulses = 0;
        for (int i = 0; i < 11; i++) begin
            egg_det = 1; tick(); pulses += int'(dozen);
            egg_det = 0; tick(); pulses += int'(dozen);
        end
        checks++;
        if (egg_cnt !== 4'd11 || pulses != 0) begin
            fails++; $display("FAIL eleven_eggs: got egg=%0d pulses=%0d expected 11/0", egg_cnt, pulses);
        end
        egg_det = 1;
        tick();
        checks++;
        if ({dozen, eject, belt_on} !== 3'b110 || egg_cnt !== 4'd12) begin
            fails++; $display("FAIL twelfth_egg: got dozen/eject/belt=%b egg=%0d expected 110/12", {dozen, eject, belt_on}, egg_cnt);
        end
        egg_det = 0;
        tick();
        tick();
        box_in = 0;
        tick();
        checks++;
        if (dozen !== 1'b0 || eject !== 1'b1 || egg_cnt !== 4'd12) begin
            fails++; $display("FAIL eject_hold: got dozen=%b eject=%b egg=%0d expected 0/1/12", dozen, eject, egg_cnt);
        end
        eject_done = 1;
        tick();
        eject_done = 0;
        checks++;
        if (box_cnt !== 7'd1 || egg_cnt !== 4'd0 || eject !== 1'b0) begin
            fails++; $display("FAIL eject_done: got box=%0d egg=%0d eject=%b expected 1/0/0", box_cnt, egg_cnt, eject);
        end
        box_in = 1;
        tick();
        checks++;
        if (belt_on !== 1'b1) begin
            fails++; $display("FAIL back_to_wait_box: got belt=%b expected 1", belt_on);
        end
    endtask

    task automatic test_held_egg();
        do_reset();
        go_fill();
        egg_det = 1;
        repeat (5) tick();
        egg_det = 0;
        tick();
        checks++;
        if (egg_cnt !== 4'd1) begin
            fails++; $display("FAIL held_egg: got egg=%0d expected 1", egg_cnt);
        end
    endtask

    task automatic test_fault();
        do_reset();
        go_fill();
        for (int i = 0; i < 5; i++) egg();
        box_in = 0;
        tick();
        checks++;
        if ({fault, belt_on} !== 2'b10 || egg_cnt !== 4'd5) begin
            fails++; $display("FAIL fault_entry: got fault/belt=%b egg=%0d expected 10/5", {fault, belt_on}, egg_cnt);
        end
        egg();
        eject_done = 1;
        box_in = 1;
        tick();
        eject_done = 0;
        checks++;
        if (fault !== 1'b1 || egg_cnt !== 4'd5 || box_cnt !== 7'd0) begin
            fails++; $display("FAIL fault_ignore: got fault=%b egg=%0d box=%0d expected 1/5/0", fault, egg_cnt, box_cnt);
        end
        box_in = 0;
        start = 1;
        tick();
        start = 0;
        checks++;
        if (fault !== 1'b0 || egg_cnt !== 4'd0) begin
            fails++; $display("FAIL fault_restart: got fault=%b egg=%0d expected 0/0", fault, egg_cnt);
        end
        box_in = 1;
        tick();
        checks++;
        if (belt_on !== 1'b1) begin
            fails++; $display("FAIL fault_to_wait_box: got belt=%b expected 1", belt_on);
        end
    endtask

    task automatic test_stop_pending();
        do_reset();
        go_fill();
        for (int i = 0; i < 3; i++) egg();
        stop = 1;
        tick();
        stop = 0;
        checks++;
        if (belt_on !== 1'b1 || egg_cnt !== 4'd3) begin
            fails++; $display("FAIL stop_latched: got belt=%b egg=%0d expected 1/3", belt_on, egg_cnt);
        end
        for (int i = 0; i < 9; i++) egg();
        checks++;
        if (eject !== 1'b1 || egg_cnt !== 4'd12) begin
            fails++; $display("FAIL stop_fill_done: got eject=%b egg=%0d expected 1/12", eject, egg_cnt);
        end
        eject_done = 1;
        tick();
        eject_done = 0;
        tick();
        checks++;
        if (box_cnt !== 7'd1 || belt_on !== 1'b0 || eject !== 1'b0) begin
            fails++; $display("FAIL stop_to_idle: got box=%0d belt=%b eject=%b expected 1/0/0", box_cnt, belt_on, eject);
        end
        start = 1;
        tick();
        start = 0;
        tick();
        checks++;
        if (belt_on !== 1'b1) begin
            fails++; $display("FAIL restart_after_stop: got belt=%b expected 1", belt_on);
        end
    endtask

    task automatic test_same_cycle_eject();
        do_reset();
        go_fill();
        for (int i = 0; i < 11; i++) egg();
        egg_det = 1;
        box_in = 0;
        tick();
        egg_det = 0;
        checks++;
        if ({eject, fault, dozen} !== 3'b101 || egg_cnt !== 4'd12) begin
            fails++; $display("FAIL twelfth_with_box_loss: got eject/fault/dozen=%b egg=%0d expected 101/12", {eject, fault, dozen}, egg_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] exp2 [3];
        exp2[0] = 7'd1; exp2[1] = 7'd2; exp2[2] = 7'd0;
        do_reset();
        start = 1;
        tick();
        start = 0;
        for (int b = 0; b < 3; b++) begin
            box_in = 1;
            tick();
            for (int i = 0; i < 12; i++) egg();
            eject_done = 1;
            tick();
            eject_done = 0;
            box_in = 0;
            tick();
            checks++;
            if (box_cnt2 !== exp2[b] || box_cnt !== 7'(b + 1)) begin
                fails++; $display("FAIL box_wrap[%0d]: got max2=%0d dflt=%0d expected %0d/%0d", b, box_cnt2, box_cnt, exp2[b], b + 1);
            end
        end
    endtask

    task automatic test_start_stop_idle();
        do_reset();
        start = 1;
        stop = 1;
        tick();
        tick();
        start = 0;
        stop = 0;
        box_in = 1;
        tick();
        tick();
        checks++;
        if (belt_on !== 1'b0) begin
            fails++; $display("FAIL start_stop_idle: got belt=%b expected 0", belt_on);
        end
        box_in = 0;
    endtask

    initial begin
        test_reset();
        test_normal_fill();
        test_held_egg();
        test_fault();
        test_stop_pending();
        test_same_cycle_eject();
        test_wrap();
        test_start_stop_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
